// File: rtl/dram_req_ctrl.sv
// dram_req_ctrl: request front-end for the 4 x 72-bit dram array.
// Buffers read/write requests in an in-order FIFO, issues them to the array
// one at a time and returns read data over a valid/ready response channel.
// Build option: define DRAM_REQ_CTRL_PARITY_EN to store per-byte even parity
// in bits [71:64] on writes and flag mismatches on reads via rsp_err.
module dram_req_ctrl #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 72,
  parameter int REQ_DEPTH = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

`ifdef DRAM_REQ_CTRL_PARITY_EN
  function automatic logic [7:0] byte_par(input logic [63:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction
  logic err_q;
`endif

  req_t             fifo [REQ_DEPTH];
  req_t             in_req;
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop;
  state_t           state;
  logic [LAT_W-1:0] wait_cnt;

  assign push = req_valid && req_ready;
  assign pop  = (state == IDLE) && (count != '0);
  assign head = fifo[rd_ptr];
  assign busy = (state != IDLE) || (count != '0);

  // Request word as stored; parity replaces the top byte when enabled.
  always_comb begin
    in_req.write = req_write;
    in_req.addr  = req_addr;
    in_req.data  = req_wdata;
`ifdef DRAM_REQ_CTRL_PARITY_EN
    in_req.data[71:64] = byte_par(req_wdata[63:0]);
`endif
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= in_req;
  end

  // FIFO pointers, occupancy and registered ready (= not full next cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      req_ready <= (count_next != CNT_W'(REQ_DEPTH));
    end
  end

  // Issue FSM: one request at a time, reads wait for data and the consumer.
  // mem_data_out is valid RD_LAT cycles after read enable drops and is
  // sampled on the following edge, giving 3 + RD_LAT push-to-response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      wait_cnt     <= '0;
`ifdef DRAM_REQ_CTRL_PARITY_EN
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (count != '0) begin
          mem_address <= head.addr;
          mem_data_in <= head.data;
          if (head.write) begin
            mem_write_en <= 1'b1;
            state        <= WR;
          end else begin
            mem_read_en <= 1'b1;
            state       <= RD;
          end
        end
        WR: begin
          mem_write_en <= 1'b0;
          state        <= IDLE;
        end
        RD: begin
          mem_read_en <= 1'b0;
          wait_cnt    <= LAT_W'(RD_LAT);
          state       <= WAIT;
        end
        WAIT: if (wait_cnt == '0) begin
          rsp_rdata <= mem_data_out;
          rsp_valid <= 1'b1;
`ifdef DRAM_REQ_CTRL_PARITY_EN
          err_q     <= (byte_par(mem_data_out[63:0]) != mem_data_out[71:64]);
`endif
          state     <= RESP;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_REQ_CTRL_PARITY_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_req_ctrl.sv
// tb_dram_req_ctrl: directed + randomized bench for dram_req_ctrl with a
// behavioural dram array and a transaction-level expectation model.
module tb_dram_req_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [71:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [71:0] rsp_rdata, mem_data_in;
  logic [71:0] mem_data_out = '0;
  logic        mem_write_en, mem_read_en;
  logic [1:0]  mem_address;
  logic [71:0] flip_mask = '0;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  dram_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Array model: data appears one cycle after the read-enable cycle ends.
  logic [71:0] dram [4];
  logic        rd_pend = 1'b0;
  logic [1:0]  rd_addr_q = '0;
  always @(posedge clk) begin
    if (mem_write_en) dram[mem_address] <= mem_data_in;
    rd_pend <= mem_read_en;
    if (mem_read_en) rd_addr_q <= mem_address;
    if (rd_pend) mem_data_out <= dram[rd_addr_q] ^ flip_mask;
  end

  function automatic logic [7:0] bpar(input logic [63:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  function automatic logic [71:0] wxform(input logic [71:0] d);
`ifdef DRAM_REQ_CTRL_PARITY_EN
    return {bpar(d[63:0]), d[63:0]};
`else
    return d;
`endif
  endfunction

  function automatic logic par_bad(input logic [71:0] d);
`ifdef DRAM_REQ_CTRL_PARITY_EN
    return bpar(d[63:0]) != d[71:64];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expectation model: queue of accepted requests in order, contents of the
  // array as the controller should have written it, one outstanding read.
  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [71:0] d;
  } op_t;
  op_t         q[$];
  int          occ = 0;
  bit          rd_act = 0, hold = 0, prev_en = 0, rst_q = 1;
  logic [71:0] ref_mem [4];
  logic [71:0] exp_rd = '0;
  logic        exp_err = 1'b0;
  logic [72:0] held = '0;

  always @(negedge clk) begin
    op_t e;
    if (rst_q) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_err, mem_write_en, mem_read_en, busy,
                            mem_address, rsp_rdata}, '0);
      chk("reset_data_in", mem_data_in, '0);
    end else begin
      if (mem_write_en || mem_read_en) begin
        chk("single_pulse", prev_en, 0);
        chk("issue_while_read", rd_act, 0);
        chk("issue_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          occ--;
          chk("issue_kind", {mem_write_en, mem_read_en}, {e.w, !e.w});
          chk("issue_addr", mem_address, e.a);
          if (e.w) begin
            chk("issue_wdata", mem_data_in, e.d);
            ref_mem[e.a] = e.d;
          end else begin
            rd_act  = 1;
            exp_rd  = ref_mem[e.a] ^ flip_mask;
            exp_err = par_bad(exp_rd);
          end
        end
      end
      chk("req_ready", req_ready, occ != DEPTH);
      chk("busy", busy, occ != 0 || mem_write_en || rd_act);
      if (hold) chk("rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, held});
      if (rsp_valid) chk("rsp_without_read", rd_act, 1);
    end
    prev_en = !rst_q && (mem_write_en || mem_read_en);
    hold = 0;
    // Events taking effect on the coming edge.
    if (rst) begin
      q.delete();
      occ    = 0;
      rd_act = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        rd_act = 0;
      end else if (rsp_valid) begin
        hold = 1;
        held = {rsp_err, rsp_rdata};
      end
      if (req_valid && req_ready) begin
        e.w = req_write; e.a = req_addr; e.d = wxform(req_wdata);
        q.push_back(e);
        occ++;
      end
    end
    rst_q = rst;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic w, input logic [1:0] a, input logic [71:0] d);
    bit acc;
    int n;
    n = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    do begin
      @(negedge clk); acc = req_ready; step(); n++;
    end while (!acc && n < 64);
    chk("push_accepted", acc, 1);
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 64);
    chk("rsp_arrived", rsp_valid, 1);
  endtask

  localparam logic [71:0] PAR_W = 72'hAB_0000_0000_0000_00FF;
`ifdef DRAM_REQ_CTRL_PARITY_EN
  localparam logic [71:0] PAR_STORED = 72'h00_0000_0000_0000_00FF;
  localparam logic        FLIP_ERR   = 1'b1;
`else
  localparam logic [71:0] PAR_STORED = PAR_W;
  localparam logic        FLIP_ERR   = 1'b0;
`endif

  initial begin
    int n, hits;
    logic [95:0] r;
    // Reset held with a request offered: nothing is accepted.
    rst = 1; req_valid = 1; req_write = 1; req_addr = 2'd1; req_wdata = 72'd5; rsp_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_hold", {req_ready, busy, mem_write_en, rsp_valid}, 0);
    step(); rst = 0; req_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    chk("busy_after_rst", busy, 0);

    // Write 12 to addr 0, then an isolated read of addr 0.
    step();
    push(1, 2'd0, 72'd12);
    @(negedge clk);
    @(negedge clk);
    chk("wr_pulse", {mem_write_en, mem_address, mem_data_in}, {1'b1, 2'd0, 72'd12});
    @(negedge clk);
    chk("wr_pulse_end", mem_write_en, 0);
    step(); step();
    push(0, 2'd0, '0);
    wait_rsp(n);
    // first negedge after push returns precedes the pop edge
    chk("rd_latency", n - 1, 4);
    chk("rd_data12", rsp_rdata, 72'd12);

    // Stall the FSM in RESP, then fill the FIFO with four writes.
    step(); rsp_ready = 0;
    push(0, 2'd0, '0);
    wait_rsp(n);
    step();
    for (int i = 0; i < 4; i++) push(1, 2'(i), 72'(11 + i));
    @(negedge clk);
    chk("full_ready", req_ready, 0);
    step(); rsp_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("ready_still_full", req_ready, 0);
    @(negedge clk);
    chk("ready_after_pop", req_ready, 1);
    step();
    push(0, 2'd2, '0);
    wait_rsp(n);
    chk("rd_data13", rsp_rdata, 72'd13);

    // Response backpressure with two reads queued.
    step(); rsp_ready = 0;
    push(0, 2'd1, '0);
    push(0, 2'd3, '0);
    wait_rsp(n);
    chk("bp_first", rsp_rdata, 72'd12);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_rdata, 72'd12);
      chk("bp_no_issue", mem_read_en, 0);
    end
    step(); rsp_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("bp_drop", rsp_valid, 0);
    wait_rsp(n);
    chk("bp_second", rsp_rdata, 72'd14);

    // Reset while a read waits for data, with another read queued.
    step();
    push(0, 2'd0, '0);
    push(0, 2'd1, '0);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("busy_after_mid_rst", busy, 0);
    hits = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid) hits++; end
    chk("no_rsp_after_rst", hits, 0);

    // Parity: clean read, then a read with bit 0 corrupted by the array.
    step();
    push(1, 2'd2, PAR_W);
    repeat (3) step();
    push(0, 2'd2, '0);
    wait_rsp(n);
    chk("par_clean_data", rsp_rdata, PAR_STORED);
    chk("par_clean_err", rsp_err, 0);
    step(); flip_mask = 72'd1;
    push(0, 2'd2, '0);
    wait_rsp(n);
    chk("par_flip_data", rsp_rdata, PAR_STORED ^ 72'd1);
    chk("par_flip_err", rsp_err, FLIP_ERR);
    step(); flip_mask = '0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      r = {$urandom, $urandom, $urandom};
      req_valid = ($urandom_range(0, 9) < 7);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 2'($urandom_range(0, 3));
      req_wdata = r[71:0];
      rsp_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    req_valid = 0; rst = 0; rsp_ready = 1;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
